// File: rtl/pair_mismatch_monitor_if.sv
// Signal bundle between the pair-driving stimulus stage and pair_mismatch_monitor.
// The master modport drives the compared pair and controls; the slave modport is the monitor side.
interface pair_mismatch_monitor_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr;
    logic             mismatch;
    logic             err_sticky;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [TS_W-1:0]  first_ts;
    logic [WIDTH-1:0] first_a;
    logic [WIDTH-1:0] first_b;
    logic             busy;

    modport master (
        output en, a, b, clr,
        input  mismatch, err_sticky, mismatch_cnt, first_ts, first_a, first_b, busy
    );

    modport slave (
        input  en, a, b, clr,
        output mismatch, err_sticky, mismatch_cnt, first_ts, first_a, first_b, busy
    );
endinterface

// File: rtl/pair_mismatch_monitor.sv
// Persistent-mismatch checker for a driven signal pair: filters one-cycle skews, pulses on confirm,
// counts episodes and captures the first one. Define PAIR_MON_ASSERT_EN to add embedded checks.
module pair_mismatch_monitor #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    pair_mismatch_monitor_if.slave bus
);
    typedef enum logic [1:0] {MATCH, PEND, MISM} state_t;

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  pend_ts;
    logic [7:0]       run;
    logic             neq;
    logic             confirm;
    logic             captured;
    logic             mismatch_r;
    logic             err_sticky_r;
    logic [CNT_W-1:0] cnt_r;
    logic [TS_W-1:0]  first_ts_r;
    logic [WIDTH-1:0] first_a_r;
    logic [WIDTH-1:0] first_b_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // X or Z on either registered input must count as unequal in simulation.
`ifdef SYNTHESIS
    assign neq = (a_q != b_q);
`else
    assign neq = (a_q !== b_q);
`endif

    always_comb begin
        confirm = 1'b0;
        case (state)
            MATCH:   confirm = bus.en && neq && (SETTLE == 1);
            PEND:    confirm = bus.en && neq && ((run + 8'd1) >= SETTLE_C);
            default: confirm = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= MATCH;
            a_q          <= '0;
            b_q          <= '0;
            ts           <= '0;
            pend_ts      <= '0;
            run          <= '0;
            captured     <= 1'b0;
            mismatch_r   <= 1'b0;
            err_sticky_r <= 1'b0;
            cnt_r        <= '0;
            first_ts_r   <= '0;
            first_a_r    <= '0;
            first_b_r    <= '0;
        end else begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            ts         <= ts + 1'b1;
            mismatch_r <= 1'b0;
            if (bus.clr) begin
                // clr overrides any confirm landing on the same edge.
                state        <= MATCH;
                run          <= '0;
                captured     <= 1'b0;
                err_sticky_r <= 1'b0;
                cnt_r        <= '0;
                first_ts_r   <= '0;
                first_a_r    <= '0;
                first_b_r    <= '0;
            end else begin
                case (state)
                    MATCH: begin
                        if (bus.en && neq) begin
                            pend_ts <= ts;
                            if (confirm) begin
                                state <= MISM;
                            end else begin
                                state <= PEND;
                                run   <= 8'd1;
                            end
                        end
                    end
                    PEND: begin
                        if (!bus.en || !neq) begin
                            state <= MATCH;
                            run   <= '0;
                        end else if (confirm) begin
                            state <= MISM;
                            run   <= '0;
                        end else begin
                            run <= run + 8'd1;
                        end
                    end
                    MISM: begin
                        if (!bus.en || !neq) state <= MATCH;
                    end
                    default: state <= MATCH;
                endcase

                if (confirm) begin
                    mismatch_r   <= 1'b1;
                    err_sticky_r <= 1'b1;
                    cnt_r        <= sat_inc(cnt_r);
                    if (!captured) begin
                        captured   <= 1'b1;
                        first_ts_r <= (state == MATCH) ? ts : pend_ts;
                        first_a_r  <= a_q;
                        first_b_r  <= b_q;
                    end
                end
            end
        end
    end

    assign bus.mismatch     = mismatch_r;
    assign bus.err_sticky   = err_sticky_r;
    assign bus.mismatch_cnt = cnt_r;
    assign bus.first_ts     = first_ts_r;
    assign bus.first_a      = first_a_r;
    assign bus.first_b      = first_b_r;
    assign bus.busy         = (state != MATCH);

`ifdef PAIR_MON_ASSERT_EN
    // A clr in the cycle after a pulse legitimately drops the sticky flag.
    property p_pulse_sets_sticky;
        @(posedge clk) disable iff (!rst_n || bus.clr) mismatch_r |=> err_sticky_r;
    endproperty

    property p_single_cycle_pulse;
        @(posedge clk) disable iff (!rst_n) mismatch_r |=> !mismatch_r;
    endproperty

    a_pulse_sets_sticky: assert property (p_pulse_sets_sticky)
        else $error("pair_mismatch_monitor: pulse without sticky at %0t", $time);

    a_single_cycle_pulse: assert property (p_single_cycle_pulse)
        else $error("pair_mismatch_monitor: pulse held two cycles at %0t", $time);

    always_comb begin
        a_busy_needs_en: assert final (!(bus.busy && !bus.en))
            else $error("pair_mismatch_monitor: busy while disabled at %0t", $time);
    end
`endif
endmodule

// File: tb/tb_pair_mismatch_monitor.sv
// Directed bench for pair_mismatch_monitor: default build plus a CNT_W=2 copy for saturation.
module tb_pair_mismatch_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ts_m = 0;
    int   t_exp;
    logic seen_mm;
    logic seen_busy;

    pair_mismatch_monitor_if #(.WIDTH(1), .CNT_W(16), .TS_W(32)) b1 ();
    pair_mismatch_monitor_if #(.WIDTH(1), .CNT_W(2),  .TS_W(32)) b2 ();

    assign b2.en  = b1.en;
    assign b2.a   = b1.a;
    assign b2.b   = b1.b;
    assign b2.clr = b1.clr;

    pair_mismatch_monitor #(.WIDTH(1), .SETTLE(2), .CNT_W(16), .TS_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    pair_mismatch_monitor #(.WIDTH(1), .SETTLE(2), .CNT_W(2), .TS_W(32)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ts_m++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mm"},     b1.mismatch,     1'b0);
        chk({tag, "_sticky"}, b1.err_sticky,   1'b0);
        chk({tag, "_cnt"},    b1.mismatch_cnt, 16'd0);
        chk({tag, "_fts"},    b1.first_ts,     32'd0);
        chk({tag, "_fa"},     b1.first_a,      1'b0);
        chk({tag, "_fb"},     b1.first_b,      1'b0);
        chk({tag, "_busy"},   b1.busy,         1'b0);
        chk({tag, "_cnt2"},   b2.mismatch_cnt, 2'd0);
    endtask

    initial begin
        b1.en  = 1'b0;
        b1.a   = 1'b0;
        b1.b   = 1'b0;
        b1.clr = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst_n = 1'b1;
        ts_m  = 0;

        // Equal inputs for 20 cycles
        b1.en = 1'b1;
        b1.a  = 1'b1;
        b1.b  = 1'b1;
        seen_mm   = 1'b0;
        seen_busy = 1'b0;
        repeat (20) begin
            tick();
            seen_mm   = seen_mm | b1.mismatch;
            seen_busy = seen_busy | b1.busy;
        end
        chk("eq_mm",     seen_mm,         1'b0);
        chk("eq_busy",   seen_busy,       1'b0);
        chk("eq_cnt",    b1.mismatch_cnt, 16'd0);
        chk("eq_sticky", b1.err_sticky,   1'b0);

        // One-cycle glitch is filtered
        b1.b = 1'b0;
        tick();
        b1.b = 1'b1;
        chk("gl_busy0", b1.busy, 1'b0);
        tick();
        chk("gl_busy1", b1.busy, 1'b1);
        chk("gl_mm1",   b1.mismatch, 1'b0);
        tick();
        chk("gl_busy2", b1.busy, 1'b0);
        chk("gl_mm2",   b1.mismatch, 1'b0);
        tick();
        chk("gl_mm3",   b1.mismatch, 1'b0);
        chk("gl_cnt",   b1.mismatch_cnt, 16'd0);

        // Confirmed episode; the PEND entry edge carries ts = t_exp
        t_exp = ts_m + 1;
        b1.a = 1'b1;
        b1.b = 1'b0;
        tick();
        tick();
        chk("c1_mm_early", b1.mismatch, 1'b0);
        chk("c1_busy",     b1.busy,     1'b1);
        tick();
        chk("c1_mm",     b1.mismatch,     1'b1);
        chk("c1_cnt",    b1.mismatch_cnt, 16'd1);
        chk("c1_sticky", b1.err_sticky,   1'b1);
        chk("c1_fts",    b1.first_ts,     32'(t_exp));
        chk("c1_fa",     b1.first_a,      1'b1);
        chk("c1_fb",     b1.first_b,      1'b0);
        tick();
        chk("c1_mm_off", b1.mismatch, 1'b0);
        chk("c1_mism",   b1.busy,     1'b1);
        // Value change that stays unequal is the same episode
        b1.a = 1'b0;
        b1.b = 1'b1;
        tick();
        chk("flip_mm0", b1.mismatch, 1'b0);
        tick();
        chk("flip_mm1", b1.mismatch, 1'b0);
        chk("flip_cnt", b1.mismatch_cnt, 16'd1);
        chk("flip_fa",  b1.first_a, 1'b1);
        b1.a = 1'b0;
        b1.b = 1'b0;
        tick();
        tick();
        chk("c1_idle", b1.busy, 1'b0);

        // Second episode keeps the first capture
        b1.a = 1'b1;
        tick();
        tick();
        chk("c2_mm_early", b1.mismatch, 1'b0);
        tick();
        chk("c2_mm",  b1.mismatch,     1'b1);
        chk("c2_cnt", b1.mismatch_cnt, 16'd2);
        chk("c2_fts", b1.first_ts,     32'(t_exp));
        b1.a = 1'b0;
        tick();
        chk("c2_mm_off", b1.mismatch, 1'b0);
        tick();

        // en dropped while pending
        b1.a = 1'b1;
        tick();
        tick();
        chk("en_pend", b1.busy, 1'b1);
        b1.en = 1'b0;
        tick();
        chk("en_busy0", b1.busy, 1'b0);
        chk("en_mm0",   b1.mismatch, 1'b0);
        tick();
        chk("en_busy1", b1.busy, 1'b0);
        chk("en_mm1",   b1.mismatch, 1'b0);
        chk("en_cnt",   b1.mismatch_cnt, 16'd2);
        chk("en_fts",   b1.first_ts, 32'(t_exp));
        b1.a = 1'b0;
        tick();
        b1.en = 1'b1;
        tick();
        tick();

        // clr lands on the confirm edge
        b1.a = 1'b1;
        tick();
        tick();
        b1.clr = 1'b1;
        tick();
        b1.clr = 1'b0;
        chk("clr_mm",     b1.mismatch,     1'b0);
        chk("clr_cnt",    b1.mismatch_cnt, 16'd0);
        chk("clr_sticky", b1.err_sticky,   1'b0);
        chk("clr_fts",    b1.first_ts,     32'd0);
        chk("clr_busy",   b1.busy,         1'b0);
        t_exp = ts_m;
        tick();
        chk("clr_pend", b1.mismatch, 1'b0);
        tick();
        chk("clr2_mm",     b1.mismatch,     1'b1);
        chk("clr2_cnt",    b1.mismatch_cnt, 16'd1);
        chk("clr2_sticky", b1.err_sticky,   1'b1);
        chk("clr2_fts",    b1.first_ts,     32'(t_exp));
        b1.a = 1'b0;
        tick();
        tick();

        // Asynchronous reset while pending
        b1.a = 1'b1;
        tick();
        tick();
        chk("arst_pend", b1.busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        b1.a = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ts_m  = 0;
        seen_mm   = 1'b0;
        seen_busy = 1'b0;
        repeat (4) begin
            tick();
            seen_mm   = seen_mm | b1.mismatch;
            seen_busy = seen_busy | b1.busy;
        end
        chk("arst_mm",   seen_mm,   1'b0);
        chk("arst_busy", seen_busy, 1'b0);

        // Saturation on the CNT_W=2 copy
        b1.clr = 1'b1;
        tick();
        b1.clr = 1'b0;
        for (int ep = 0; ep < 5; ep++) begin
            b1.a = 1'b1;
            tick();
            tick();
            tick();
            chk("sat_mm", b2.mismatch, 1'b1);
            b1.a = 1'b0;
            tick();
            tick();
        end
        chk("sat_cnt2", b2.mismatch_cnt, 2'd3);
        chk("sat_cnt",  b1.mismatch_cnt, 16'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
